// File: rtl/bus_timer_pkg.sv
// Shared definitions for the bus_timer countdown timer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the FSM state encoding, register word offsets, CTRL field bit
// positions and MODE encodings used by bus_timer and its testbench.

package bus_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    // Word offsets within the device window (PrAddr[3:2]); offset 3 is reserved.
    localparam logic [1:0] OFS_CTRL   = 2'd0;
    localparam logic [1:0] OFS_PRESET = 2'd1;
    localparam logic [1:0] OFS_COUNT  = 2'd2;

    // CTRL field positions.
    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LO  = 1;
    localparam int CTRL_MODE_HI  = 2;
    localparam int CTRL_IM       = 3;
    localparam int CTRL_PRESC_LO = 4;
    localparam int CTRL_PRESC_HI = 7;

    // MODE encodings; 2'b1x behaves as one-shot.
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/bus_timer_prescaler.sv
// 4-bit prescale counter: tick is high while the count equals the prescale value P.
// Latency: tick is combinational from the counter; the counter steps every cycle run is high.
// Backpressure: none; clr (timer LOAD) has priority over run.
//
// Only built when BUS_TIMER_PRESCALE_EN is defined.
// Ports: clk, reset (async active-low), clr, run, presc[3:0] in; tick out.

`ifdef BUS_TIMER_PRESCALE_EN
module bus_timer_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       run,
    input  logic [3:0] presc,
    output logic       tick
);

    logic [3:0] psc_cnt;

    assign tick = (psc_cnt == presc);

    // Counts 0..P while running; restarts after every tick (each decrement)
    // and whenever the timer reloads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc_cnt <= 4'd0;
        end else if (clr) begin
            psc_cnt <= 4'd0;
        end else if (run) begin
            psc_cnt <= tick ? 4'd0 : psc_cnt + 4'd1;
        end
    end

endmodule
`endif

// File: rtl/bus_timer.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) with one interrupt line.
// Latency: reads combinational (zero cycles); writes take effect at the sampling edge.
// Backpressure: none; every access completes in its own cycle.
//
// Ports: clk, reset (async active-low), sel, addr[1:0], we, wd[31:0] in;
//        rd[31:0] (combinational read data), irq out.
// Optional macro BUS_TIMER_PRESCALE_EN adds a 4-bit prescale field CTRL[7:4];
// when undefined COUNT decrements every CNT cycle and CTRL[7:4] reads 0.

module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [31:0] RESET_PRESET = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    state_t      state_q;
    logic        ctrl_en;
    logic [1:0]  ctrl_mode;
    logic        ctrl_im;
    logic [3:0]  ctrl_presc;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        irq_pend;
    logic        tick;

    logic wr_ctrl;
    logic wr_preset;

    assign wr_ctrl   = sel && we && (addr == OFS_CTRL);
    assign wr_preset = sel && we && (addr == OFS_PRESET);

`ifdef BUS_TIMER_PRESCALE_EN
    logic wd_unused;
    assign wd_unused = ^wd[31:8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_presc <= 4'd0;
        end else if (wr_ctrl) begin
            ctrl_presc <= wd[CTRL_PRESC_HI:CTRL_PRESC_LO];
        end
    end

    bus_timer_prescaler u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == LOAD),
        .run   (state_q == CNT),
        .presc (ctrl_presc),
        .tick  (tick)
    );
`else
    logic wd_unused;
    assign wd_unused  = ^wd[31:4];
    assign ctrl_presc = 4'd0;
    assign tick       = 1'b1;
`endif

    // Control FSM and register file. A CTRL/PRESET write outranks the FSM
    // entirely on its edge: the written CTRL value beats INT's EN clear, the
    // state restarts from IDLE, the pending interrupt is dropped and COUNT
    // is left alone (even if the FSM was in LOAD).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ctrl_en   <= 1'b0;
            ctrl_mode <= MODE_ONESHOT;
            ctrl_im   <= 1'b0;
            preset_q  <= RESET_PRESET;
            count_q   <= 32'd0;
            irq_pend  <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en   <= wd[CTRL_EN];
                ctrl_mode <= wd[CTRL_MODE_HI:CTRL_MODE_LO];
                ctrl_im   <= wd[CTRL_IM];
            end
            if (wr_preset) begin
                preset_q <= wd;
            end

            if (wr_ctrl || wr_preset) begin
                state_q  <= IDLE;
                irq_pend <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (ctrl_en) begin
                            state_q <= LOAD;
                        end
                    end
                    LOAD: begin
                        count_q <= preset_q;
                        state_q <= CNT;
                    end
                    CNT: begin
                        if (!ctrl_en) begin
                            state_q <= IDLE;
                        end else if (tick) begin
                            // Expiry is detected one tick after COUNT reaches 0,
                            // so PRESET=0 still spends one tick in CNT.
                            if (count_q == 32'd0) begin
                                state_q  <= INT;
                                irq_pend <= 1'b1;
                            end else begin
                                count_q <= count_q - 32'd1;
                            end
                        end
                    end
                    INT: begin
                        if (ctrl_mode == MODE_RELOAD) begin
                            irq_pend <= 1'b0;
                            state_q  <= LOAD;
                        end else begin
                            // One-shot (and 2'b1x): stop and hold the interrupt
                            // until software rewrites CTRL or PRESET.
                            ctrl_en <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign irq = irq_pend & ctrl_im;

    always_comb begin
        rd = 32'd0;
        case (addr)
            OFS_CTRL:   rd = {24'd0, ctrl_presc, ctrl_im, ctrl_mode, ctrl_en};
            OFS_PRESET: rd = preset_q;
            OFS_COUNT:  rd = count_q;
            default:    rd = 32'd0;
        endcase
    end

endmodule
